// File: rtl/corr_seq128.sv
// =============================================================================
// Module      : corr_seq128
// Description : Sequencer for a 128-lag RAM-based MAC bank. Captures 8-bit
//               samples into a 128-deep history, drives the bank's clear /
//               multiply-accumulate / read controls so lag k accumulates
//               x[n]*x[n-k] over a programmed integration length, then drains
//               all 128 lag sums to a valid/ready output stream.
//               Optional macro CORR_CROSS_EN adds input s_data_b; the history
//               then holds s_data_b (cross-correlation a[n]*b[n-k]).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module corr_seq128 #(
   parameter int AW = 7,
   parameter int NW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [NW-1:0] int_len,
   input  logic          s_valid,
   input  logic [7:0]    s_data,
`ifdef CORR_CROSS_EN
   input  logic [7:0]    s_data_b,
`endif
   output logic          mac_sin,
   output logic          mac_clr,
   output logic          mac_read,
   output logic [7:0]    mac_A,
   output logic [7:0]    mac_B,
   output logic [AW-1:0] mac_rAddr,
   input  logic [31:0]   mac_rData,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [AW-1:0] o_lag,
   output logic [31:0]   o_data,
   output logic          busy,
   output logic          done,
   output logic          overrun
);

   localparam int DEPTH = 2 ** AW;
   // CLR lasts DEPTH+2 cycles: one clear strobe cycle plus DEPTH+1 settle cycles
   localparam logic [AW:0] CLR_LAST = (AW + 1)'(DEPTH + 1);
   localparam logic [AW:0] MAC_LAST = (AW + 1)'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_WAIT = 3'd2,
      S_MAC  = 3'd3,
      S_DUMP = 3'd4,
      S_GAP  = 3'd5
   } state_t;

   state_t        state;
   state_t        state_nx;

   logic [AW:0]   cnt;        // CLR cycle counter / MAC lag counter
   logic [AW-1:0] wp;         // history write pointer (lag 0 position)
   logic [NW-1:0] len_q;      // latched integration length
   logic [NW-1:0] n_cnt;      // samples integrated so far
   logic [1:0]    wcnt;       // read-latency wait counter in DUMP
   logic          to_dump;    // last MAC of the integration finished

   logic [7:0]    hist [DEPTH];
   logic          hist_we;
   logic [7:0]    hist_wdata;
   logic [7:0]    sample_hist;

`ifdef CORR_CROSS_EN
   assign sample_hist = s_data_b;
`else
   assign sample_hist = s_data;
`endif

   assign busy = (state != S_IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (start && int_len != '0) state_nx = S_CLR;
         S_CLR:  if (cnt == CLR_LAST) state_nx = S_WAIT;
         S_WAIT: if (s_valid) state_nx = S_MAC;
         S_MAC:  if (cnt == MAC_LAST) state_nx = S_GAP;
         S_GAP:  state_nx = to_dump ? S_DUMP : S_WAIT;
         S_DUMP: if (o_valid && o_ready && mac_rAddr == '1) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // History write port: zero-fill during CLR, sample capture in WAIT
   always_comb begin
      hist_we    = 1'b0;
      hist_wdata = '0;
      if (state == S_CLR && !cnt[AW]) begin
         hist_we = 1'b1;
      end else if (state == S_WAIT && s_valid) begin
         hist_we    = 1'b1;
         hist_wdata = sample_hist;
      end
   end

   // History RAM storage (contents need no reset; CLR zero-fills it)
   always_ff @(posedge clk) begin
      if (hist_we) begin
         hist[wp] <= hist_wdata;
      end
   end

   // Datapath: bank controls, counters, output stream and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mac_sin   <= 1'b0;
         mac_clr   <= 1'b0;
         mac_read  <= 1'b0;
         mac_A     <= '0;
         mac_B     <= '0;
         mac_rAddr <= '0;
         o_valid   <= 1'b0;
         o_lag     <= '0;
         o_data    <= '0;
         done      <= 1'b0;
         overrun   <= 1'b0;
         cnt       <= '0;
         wp        <= '0;
         len_q     <= '0;
         n_cnt     <= '0;
         wcnt      <= '0;
         to_dump   <= 1'b0;
      end else begin
         mac_sin <= 1'b0;
         mac_clr <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && int_len != '0) begin
                  len_q   <= int_len;
                  n_cnt   <= '0;
                  cnt     <= '0;
                  wp      <= '0;
                  to_dump <= 1'b0;
                  mac_clr <= 1'b1;
                  overrun <= 1'b0;
               end
            end
            S_CLR: begin
               cnt <= cnt + 1'b1;
               // pointer walks 0..DEPTH-1 and wraps back to 0
               if (!cnt[AW]) wp <= wp + 1'b1;
            end
            S_WAIT: begin
               if (s_valid) begin
                  mac_sin <= 1'b1;
                  mac_A   <= s_data;
                  cnt     <= '0;
               end
            end
            S_MAC: begin
               // lag k operand: sample written k samples before the current one
               mac_B <= hist[wp - cnt[AW-1:0]];
               cnt   <= cnt + 1'b1;
               if (cnt == MAC_LAST) begin
                  wp      <= wp + 1'b1;
                  n_cnt   <= n_cnt + 1'b1;
                  to_dump <= ((n_cnt + 1'b1) == len_q);
               end
            end
            S_GAP: begin
               if (to_dump) begin
                  mac_read  <= 1'b1;
                  mac_rAddr <= '0;
                  // first address after mac_read rises needs one extra cycle
                  wcnt      <= 2'd3;
               end
            end
            S_DUMP: begin
               if (!o_valid) begin
                  if (wcnt == 2'd0) begin
                     o_valid <= 1'b1;
                     o_data  <= mac_rData;
                     o_lag   <= mac_rAddr;
                  end else begin
                     wcnt <= wcnt - 1'b1;
                  end
               end else if (o_ready) begin
                  o_valid <= 1'b0;
                  if (mac_rAddr == '1) begin
                     mac_read  <= 1'b0;
                     mac_rAddr <= '0;
                     done      <= 1'b1;
                  end else begin
                     mac_rAddr <= mac_rAddr + 1'b1;
                     wcnt      <= 2'd2;
                  end
               end
            end
            default: ;
         endcase
         // a sample arriving while not waiting for one is lost
         if (s_valid && state != S_WAIT) overrun <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_corr_seq128.sv
// =============================================================================
// Module      : tb_corr_seq128
// Description : Self-checking bench for corr_seq128. Contains a behavioural
//               MAC bank, a correlation reference computed from the list of
//               accepted samples, and a per-cycle output stream checker.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_corr_seq128;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] int_len = '0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = '0;
   logic [7:0]  s_data_b = '0;
   logic        mac_sin, mac_clr, mac_read;
   logic [7:0]  mac_A, mac_B;
   logic [6:0]  mac_rAddr;
   logic [31:0] mac_rData;
   logic        o_valid;
   logic        o_ready = 1'b1;
   logic [6:0]  o_lag;
   logic [31:0] o_data;
   logic        busy, done, overrun;

   always #5 clk = ~clk;

   corr_seq128 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .int_len   (int_len),
      .s_valid   (s_valid),
      .s_data    (s_data),
`ifdef CORR_CROSS_EN
      .s_data_b  (s_data_b),
`endif
      .mac_sin   (mac_sin),
      .mac_clr   (mac_clr),
      .mac_read  (mac_read),
      .mac_A     (mac_A),
      .mac_B     (mac_B),
      .mac_rAddr (mac_rAddr),
      .mac_rData (mac_rData),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_lag     (o_lag),
      .o_data    (o_data),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // ---------------- behavioural MAC bank ----------------
   logic [31:0] acc [128];
   logic        armed = 1'b0;
   int          mcnt = 0;
   logic [7:0]  ma = '0;
   logic        rd_d = 1'b0;
   logic [31:0] p1 = '0, p2 = '0;

   assign mac_rData = p2;

   // Bank: clear, 128-cycle MAC sweep after mac_sin, 2-cycle read pipe (+1 on read rise)
   always @(posedge clk) begin
      if (!rst_n) begin
         armed <= 1'b0;
         rd_d  <= 1'b0;
         p1    <= '0;
         p2    <= '0;
      end else begin
         if (mac_clr) for (int k = 0; k < 128; k++) acc[k] <= '0;
         if (armed) begin
            acc[mcnt] <= acc[mcnt] + 32'(ma) * 32'(mac_B);
            if (mcnt == 127) armed <= 1'b0;
            mcnt <= mcnt + 1;
         end
         if (mac_sin) begin
            armed <= 1'b1;
            mcnt  <= 0;
            ma    <= mac_A;
         end
         rd_d <= mac_read;
         if (mac_read && rd_d) p1 <= acc[mac_rAddr];
         p2 <= p1;
      end
   end

   // ---------------- reference model ----------------
   int unsigned qa[$];
   int unsigned qb[$];
   logic [31:0] exp_v [128];
   logic [31:0] got   [128];
   int          exp_idx = 0;
   int          done_cnt = 0;
   int          stall_seen = 0;

   function automatic void compute_model();
      for (int k = 0; k < 128; k++) begin
         longint s = 0;
         for (int n = k; n < qa.size(); n++) s += longint'(qa[n]) * longint'(qb[n-k]);
         exp_v[k] = s[31:0];
      end
   endfunction

   // ---------------- downstream ready driver ----------------
   int rdy_mode = 0;
   int held = 0;
   always begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
         o_ready = 1'b1;
      end else if (rdy_mode == 1) begin
         o_ready = ($urandom_range(0, 2) != 0);
      end else begin
         if (o_valid && (o_lag == 7'd0 || o_lag == 7'd64) && held < 5) begin
            o_ready = 1'b0;
            held++;
         end else begin
            o_ready = 1'b1;
            if (!o_valid) held = 0;
         end
      end
   end

   // ---------------- per-cycle output checker ----------------
   bit          hold_prev = 1'b0;
   logic [31:0] pd = '0;
   logic [6:0]  pl = '0;

   // Compare stream, hold behaviour, control exclusivity and done on every cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev = 1'b0;
      end else begin
         chk("ctrl_exclusive", int'(mac_sin) + int'(mac_clr) + int'(mac_read) <= 1, 1);
         if (hold_prev) begin
            stall_seen++;
            chk("hold_valid", o_valid, 1);
            chk("hold_data", o_data, pd);
            chk("hold_lag", o_lag, pl);
         end
         if (o_valid && o_ready) begin
            if (exp_idx < 128) begin
               chk("lag_order", o_lag, exp_idx);
               chk("lag_data", o_data, exp_v[exp_idx]);
               got[o_lag] = o_data;
            end else begin
               checks++;
               errors++;
               $display("FAIL extra_word: got lag %0d after 128 words, expected none", o_lag);
            end
            exp_idx++;
         end
         if (done) begin
            done_cnt++;
            chk("done_all_words", exp_idx, 128);
            chk("done_busy_low", busy, 0);
         end
         hold_prev = o_valid && !o_ready;
         pd = o_data;
         pl = o_lag;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic check_zero(input string tag);
      chk({tag, "_ctrl"}, {mac_sin, mac_clr, mac_read, o_valid, busy, done, overrun}, 0);
      chk({tag, "_ops"}, {mac_A, mac_B, mac_rAddr, o_lag}, 0);
      chk({tag, "_odata"}, o_data, 0);
   endtask

   task automatic poke_start(input int len);
      @(posedge clk); #1;
      start = 1'b1;
      int_len = 16'(len);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic begin_run(input int len);
      qa.delete();
      qb.delete();
      exp_idx = 0;
      done_cnt = 0;
      for (int k = 0; k < 128; k++) got[k] = 32'hDEAD_BEEF;
      poke_start(len);
      @(negedge clk);
      chk("start_busy", busy, 1);
      chk("start_clr_pulse", mac_clr, 1);
      chk("start_overrun_clr", overrun, 0);
   endtask

   task automatic pulse_sample(input int a, input int b);
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data = 8'(a);
      s_data_b = 8'(b);
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic feed(input int a, input int b, input int gap);
      repeat (gap) @(posedge clk);
      pulse_sample(a, b);
      qa.push_back(a);
`ifdef CORR_CROSS_EN
      qb.push_back(b);
`else
      qb.push_back(a);
`endif
   endtask

   task automatic finish_run(input int exp_ovr);
      int i;
      compute_model();
      i = 0;
      while (done_cnt == 0 && i < 4000) begin
         @(negedge clk);
         i++;
      end
      if (done_cnt == 0) chk("done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt, 1);
      chk("words_total", exp_idx, 128);
      chk("idle_busy", busy, 0);
      chk("overrun_flag", overrun, exp_ovr);
   endtask

   function automatic longint sum_rest(input int from);
      longint s = 0;
      for (int k = from; k < 128; k++) s += longint'(got[k]);
      return s;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      repeat (3) @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // start with zero length is ignored
      poke_start(0);
      @(negedge clk);
      chk("len0_ignored", busy, 0);

      // single sample 3
      begin_run(1);
      feed(3, 3, 145);
      finish_run(0);
      chk("t1_lag0", got[0], 9);
      chk("t1_rest", sum_rest(1), 0);

      // three samples of 2; a start while busy must be ignored
      begin_run(3);
      feed(2, 2, 145);
      poke_start(1);
      feed(2, 2, 145);
      feed(2, 2, 145);
      finish_run(0);
      chk("t2_lag0", got[0], 12);
      chk("t2_lag1", got[1], 8);
      chk("t2_lag2", got[2], 4);
      chk("t2_rest", sum_rest(3), 0);

      // sample 10 cycles after the first is dropped
      begin_run(2);
      feed(5, 5, 145);
      repeat (8) @(posedge clk);
      pulse_sample(7, 7);
      feed(9, 9, 145);
      finish_run(1);
      chk("t3_lag0", got[0], 106);
      chk("t3_lag1", got[1], 45);

      // backpressure on lags 0 and 64
      rdy_mode = 2;
      stall_seen = 0;
      begin_run(2);
      feed(4, 4, 145);
      feed(6, 6, 145);
      finish_run(0);
      chk("t4_lag0", got[0], 52);
      chk("t4_lag1", got[1], 24);
      chk("t4_stalls", stall_seen, 10);
      rdy_mode = 0;

      // reset in the middle of the MAC sweep
      begin_run(1);
      feed(3, 3, 145);
      repeat (50) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check_zero("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      begin_run(1);
      feed(1, 1, 145);
      finish_run(0);
      chk("t5_lag0", got[0], 1);
      chk("t5_rest", sum_rest(1), 0);

`ifdef CORR_CROSS_EN
      begin_run(2);
      feed(1, 5, 145);
      feed(2, 7, 145);
      finish_run(0);
      chk("cross_lag0", got[0], 19);
      chk("cross_lag1", got[1], 10);
      chk("cross_rest", sum_rest(2), 0);
`endif

      // full-scale samples
      begin_run(3);
      for (int n = 0; n < 3; n++) feed(255, 255, 145);
      finish_run(0);
      chk("max_lag0", got[0], 3 * 65025);

      // randomized integrations
      for (int r = 0; r < 8; r++) begin
         int len;
         len = $urandom_range(1, 4);
         rdy_mode = $urandom_range(0, 1);
         begin_run(len);
         for (int n = 0; n < len; n++)
            feed($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(140, 170));
         finish_run(0);
      end
      rdy_mode = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
